// File: rtl/keypad_pkg.sv
// Shared types, key constants, FSM encoding and the 4x4 keypad key map used by
// the keypad reader and its decoder.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_A    = 4'hA;
    localparam key_code_t KEY_B    = 4'hB;
    localparam key_code_t KEY_C    = 4'hC;
    localparam key_code_t KEY_D    = 4'hD;
    localparam key_code_t KEY_STAR = 4'hE;
    localparam key_code_t KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        DECODE   = 2'd2,
        WAIT_LOW = 2'd3
    } lector_state_t;

    // Indexed [row][column], both 0-based.
    localparam key_code_t KEY_MAP [4][4] = '{
        '{4'h1,     4'h2, 4'h3,     KEY_A},
        '{4'h4,     4'h5, 4'h6,     KEY_B},
        '{4'h7,     4'h8, 4'h9,     KEY_C},
        '{KEY_STAR, 4'h0, KEY_HASH, KEY_D}
    };

    function automatic logic is_digit(input key_code_t code);
        return (code <= 4'h9);
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// Registered one-hot column/row to key-code decoder; flags whether both
// vectors were genuinely one-hot.
module keypad_decode
    import keypad_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_col,
    input  logic [WIDTH-1:0] i_row,
    output key_code_t        o_code,
    output logic             o_valid_onehot
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IW-1:0] w_col_idx;
    logic [IW-1:0] w_row_idx;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Position of the set bit; only meaningful when the vector is one-hot.
    always_comb begin
        w_col_idx = '0;
        w_row_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_col[i]) begin
                w_col_idx = IW'(i);
            end else begin
                w_col_idx = w_col_idx;
            end
            if (i_row[i]) begin
                w_row_idx = IW'(i);
            end else begin
                w_row_idx = w_row_idx;
            end
        end
    end

    // Decode result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_code         <= 4'h0;
            o_valid_onehot <= 1'b0;
        end else begin
            o_code         <= KEY_MAP[w_row_idx][w_col_idx];
            o_valid_onehot <= is_onehot(i_col) && is_onehot(i_row);
        end
    end

endmodule

// File: rtl/lector_teclado.sv
// Keypad reader: acknowledges the scanner handshake, decodes keys and builds a
// BCD entry number that is published on the enter (#) key.
module lector_teclado
    import keypad_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_DIGITS = 3,
    parameter int ACK_RETRY  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WIDTH-1:0]                     pressed_col_in,
    input  logic [WIDTH-1:0]                     pressed_row_in,
    input  logic                                 pressed_valid,
    output logic                                 ack_read,
    output logic [3:0]                           key_code,
    output logic                                 key_strobe,
    output logic                                 key_error,
    output logic [4*MAX_DIGITS-1:0]              entry_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count,
    output logic                                 overflow,
    output logic [4*MAX_DIGITS-1:0]              num_out,
    output logic                                 num_valid
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int RW = $clog2(ACK_RETRY + 1);

    lector_state_t          r_state;
    lector_state_t          w_next_state;
    logic [WIDTH-1:0]       r_col;
    logic [WIDTH-1:0]       r_row;
    key_code_t              w_dec_code;
    logic                   w_dec_valid;
    logic [RW-1:0]          r_retry;
    logic                   r_ack;
    key_code_t              r_key_code;
    logic                   r_key_strobe;
    logic                   r_key_error;
    logic [4*MAX_DIGITS-1:0] r_entry;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic [4*MAX_DIGITS-1:0] r_num;
    logic                   r_num_valid;

    keypad_decode #(.WIDTH(WIDTH)) u_decode (
        .clk            (clk),
        .rst            (rst),
        .i_col          (r_col),
        .i_row          (r_row),
        .o_code         (w_dec_code),
        .o_valid_onehot (w_dec_valid)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (pressed_valid) begin
                    w_next_state = CAPTURE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CAPTURE:  w_next_state = DECODE;
            DECODE:   w_next_state = WAIT_LOW;
            WAIT_LOW: begin
                if (!pressed_valid) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT_LOW;
                end
            end
            default:  w_next_state = IDLE;
        endcase
    end

    // Latch the scanner vectors once, so later input changes cannot disturb the key.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if ((r_state == IDLE) && pressed_valid) begin
            r_col <= pressed_col_in;
            r_row <= pressed_row_in;
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

    // Handshake outputs, key reporting and the ack retry timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack        <= 1'b0;
            r_key_code   <= 4'h0;
            r_key_strobe <= 1'b0;
            r_key_error  <= 1'b0;
            r_retry      <= '0;
        end else begin
            r_ack        <= 1'b0;
            r_key_strobe <= 1'b0;
            r_key_error  <= 1'b0;
            r_retry      <= '0;
            if (r_state == DECODE) begin
                r_ack <= 1'b1;
                if (w_dec_valid) begin
                    r_key_strobe <= 1'b1;
                    r_key_code   <= w_dec_code;
                end else begin
                    r_key_error  <= 1'b1;
                end
            end else if ((r_state == WAIT_LOW) && pressed_valid) begin
                // Scanner has not released yet: re-acknowledge every ACK_RETRY cycles.
                if (r_retry == RW'(ACK_RETRY - 1)) begin
                    r_ack   <= 1'b1;
                    r_retry <= '0;
                end else begin
                    r_retry <= r_retry + 1'b1;
                end
            end else begin
                r_retry <= '0;
            end
        end
    end

    // Entry buffer actions, applied the cycle after a valid key is reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_num       <= '0;
            r_num_valid <= 1'b0;
        end else begin
            r_num_valid <= 1'b0;
            if (r_key_strobe) begin
                if (is_digit(r_key_code)) begin
                    if (r_count < CW'(MAX_DIGITS)) begin
                        r_entry <= {r_entry[4*MAX_DIGITS-5:0], r_key_code};
                        r_count <= r_count + 1'b1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else if (r_key_code == KEY_STAR) begin
                    r_entry    <= '0;
                    r_count    <= '0;
                    r_overflow <= 1'b0;
                end else if ((r_key_code == KEY_HASH) && (r_count != '0)) begin
                    r_num       <= r_entry;
                    r_num_valid <= 1'b1;
                    r_entry     <= '0;
                    r_count     <= '0;
                    r_overflow  <= 1'b0;
                end else begin
                    r_entry <= r_entry;
                end
            end else begin
                r_entry <= r_entry;
            end
        end
    end

    assign ack_read    = r_ack;
    assign key_code    = r_key_code;
    assign key_strobe  = r_key_strobe;
    assign key_error   = r_key_error;
    assign entry_bcd   = r_entry;
    assign digit_count = r_count;
    assign overflow    = r_overflow;
    assign num_out     = r_num;
    assign num_valid   = r_num_valid;

endmodule

// File: tb/tb_lector_teclado.sv
// Directed self-checking bench for lector_teclado.
module tb_lector_teclado;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        pv;
    logic        ack_read;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic        key_error;
    logic [11:0] entry_bcd;
    logic [1:0]  digit_count;
    logic        overflow;
    logic [11:0] num_out;
    logic        num_valid;

    int n_total = 0;
    int n_pass  = 0;
    int n_ack = 0, n_strobe = 0, n_err = 0, n_numv = 0;
    int a0, s0, e0, v0;
    int lat;

    lector_teclado dut (
        .clk            (clk),
        .rst            (rst),
        .pressed_col_in (col),
        .pressed_row_in (row),
        .pressed_valid  (pv),
        .ack_read       (ack_read),
        .key_code       (key_code),
        .key_strobe     (key_strobe),
        .key_error      (key_error),
        .entry_bcd      (entry_bcd),
        .digit_count    (digit_count),
        .overflow       (overflow),
        .num_out        (num_out),
        .num_valid      (num_valid)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (ack_read)   n_ack++;
        if (key_strobe) n_strobe++;
        if (key_error)  n_err++;
        if (num_valid)  n_numv++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic snap();
        a0 = n_ack; s0 = n_strobe; e0 = n_err; v0 = n_numv;
    endtask

    // Drive a raw col/row pair, hold until one cycle after ack, then release.
    task automatic press_raw(input logic [3:0] c, input logic [3:0] r);
        int waited;
        logic seen;
        @(negedge clk);
        col = c; row = r; pv = 1'b1;
        seen = 1'b0; waited = 0;
        while (!seen && waited < 10) begin
            @(negedge clk);
            waited++;
            if (ack_read) seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
        lat = waited;
        @(negedge clk);
        pv = 1'b0; col = 4'h0; row = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        logic [3:0] vc, vr;
        vc = 4'b0001 << c;
        vr = 4'b0001 << r;
        press_raw(vc, vr);
    endtask

    initial begin
        rst = 1'b1; pv = 1'b0; col = 4'h0; row = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack_read, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_entry", entry_bcd, 12'h000);
        check("rst_num_out", num_out, 12'h000);
        rst = 1'b0;
        @(negedge clk);

        // Keys 4, 2, 7, #
        snap();
        press(1, 0);
        check("lat_ack", lat, 3);
        check("entry_4", entry_bcd, 12'h004);
        check("code_4", key_code, 4'h4);
        press(0, 1);
        check("entry_42", entry_bcd, 12'h042);
        press(2, 0);
        check("entry_427", entry_bcd, 12'h427);
        check("count_3", digit_count, 2'd3);
        press(3, 2);
        check("num_out_427", num_out, 12'h427);
        check("entry_clr", entry_bcd, 12'h000);
        check("count_clr", digit_count, 2'd0);
        check("acks_4", n_ack - a0, 4);
        check("strobes_4", n_strobe - s0, 4);
        check("numv_1", n_numv - v0, 1);

        // Keys 1, 2, 3, 5 then *
        press(0, 0); press(0, 1); press(0, 2); press(1, 1);
        check("entry_123", entry_bcd, 12'h123);
        check("overflow_set", overflow, 1'b1);
        snap();
        press(3, 0);
        check("star_entry", entry_bcd, 12'h000);
        check("star_overflow", overflow, 1'b0);
        check("star_count", digit_count, 2'd0);
        check("star_numv", n_numv - v0, 0);
        check("code_star", key_code, 4'hE);

        // Non-one-hot column
        press(1, 1);
        snap();
        press_raw(4'b0110, 4'b0001);
        check("err_pulse", n_err - e0, 1);
        check("err_ack", n_ack - a0, 1);
        check("err_strobe", n_strobe - s0, 0);
        check("err_entry", entry_bcd, 12'h005);
        check("err_code", key_code, 4'h5);

        // Scanner ignores ack: hold 40 cycles on key A
        snap();
        @(negedge clk);
        col = 4'b1000; row = 4'b0001; pv = 1'b1;
        repeat (40) @(negedge clk);
        pv = 1'b0; col = 4'h0; row = 4'h0;
        repeat (4) @(negedge clk);
        check("retry_acks", n_ack - a0, 3);
        check("retry_strobe", n_strobe - s0, 1);
        check("code_A", key_code, 4'hA);
        check("A_entry", entry_bcd, 12'h005);

        // # on empty buffer, then D
        press(3, 0);
        snap();
        press(3, 2);
        check("hash_empty_code", key_code, 4'hF);
        check("hash_empty_numv", n_numv - v0, 0);
        check("hash_empty_num", num_out, 12'h427);
        check("hash_empty_strobe", n_strobe - s0, 1);
        press(3, 3);
        check("code_D", key_code, 4'hD);
        check("D_entry", entry_bcd, 12'h000);

        // Reset while in WAIT_LOW with pressed_valid held high
        @(negedge clk);
        col = 4'b0100; row = 4'b0100; pv = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_entry", entry_bcd, 12'h009);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_entry", entry_bcd, 12'h000);
        check("mid_rst_code", key_code, 4'h0);
        check("mid_rst_num", num_out, 12'h000);
        check("mid_rst_ack", ack_read, 1'b0);
        check("mid_rst_count", digit_count, 2'd0);
        rst = 1'b0; pv = 1'b0; col = 4'h0; row = 4'h0;
        repeat (2) @(negedge clk);
        press(1, 2);
        check("post_rst_entry", entry_bcd, 12'h006);
        check("post_rst_code", key_code, 4'h6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lector_teclado.md
Name: lector_teclado

Overview:
- Consumer end of the keypad read handshake. Takes the latched one-hot column/row pair and `pressed_valid` from the keypad scanning system, decodes it to a 4-bit key code, and returns a one-cycle `ack_read` pulse.
- Accumulates decimal digits into a BCD entry buffer and publishes a completed number when the enter key is pressed.
- Sits between the keypad scanner and the arithmetic/display blocks.

Parameters:
- WIDTH, 4, keypad rows/columns; one-hot input width.
- MAX_DIGITS, 3, BCD digits held in the entry buffer.
- ACK_RETRY, 16, cycles to wait in WAIT_LOW before re-pulsing `ack_read`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pressed_col_in  in  WIDTH  one-hot column from scanner.
- pressed_row_in  in  WIDTH  one-hot row from scanner.
- pressed_valid  in  1  scanner holds high until acked.
- ack_read  out  1  one-cycle acknowledge to scanner.
- key_code  out  4  last decoded key, held until the next key.
- key_strobe  out  1  one-cycle pulse when `key_code` updates.
- key_error  out  1  one-cycle pulse on a non-one-hot row or column.
- entry_bcd  out  4*MAX_DIGITS  live entry buffer, for the display.
- digit_count  out  $clog2(MAX_DIGITS+1)  digits currently in the entry buffer.
- overflow  out  1  sticky; a digit arrived while the buffer was full.
- num_out  out  4*MAX_DIGITS  last committed number.
- num_valid  out  1  one-cycle pulse when `num_out` loads.

Behaviour:
- Reset (priority over all other activity, in any state): state=IDLE. All outputs 0, `key_code`=0. Buffers cleared, retry counter=0.
- Key map, row r / column c, 0-based:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Codes: digits 0–9 map to 0x0–0x9; A–D map to 0xA–0xD; * = 0xE; # = 0xF.
- FSM states: IDLE, CAPTURE, DECODE, WAIT_LOW.
  - IDLE: when `pressed_valid`=1, register the col/row inputs and go to CAPTURE.
  - CAPTURE: one cycle; the decode result is registered. Go to DECODE.
  - DECODE: `ack_read`=1 for exactly this cycle. Then go to WAIT_LOW.
    - If both vectors are one-hot: `key_strobe`=1 and `key_code` updates; apply the entry action at the end of this cycle.
    - Otherwise: `key_error`=1, no strobe, no entry change.
  - WAIT_LOW: go to IDLE when `pressed_valid`=0.
    - The retry counter increments each cycle. On reaching ACK_RETRY, pulse `ack_read` again for one cycle and restart the count.
    - No new key is accepted until `pressed_valid` has been seen low.
- Latency: from the `pressed_valid` rise sampled in IDLE, `ack_read`/`key_strobe` go high 2 cycles later. `entry_bcd` and `num_out` change on the following edge.
- Entry actions, all in DECODE:
  - Digit, count<MAX_DIGITS: shift `entry_bcd` left by 4, new digit into the low nibble, count+1.
  - Digit, count==MAX_DIGITS: buffer unchanged; `overflow`<=1.
  - `*`: clear `entry_bcd`, clear count, clear `overflow`.
  - `#` with count>0: `num_out`<=`entry_bcd`, `num_valid`=1 the next cycle. Clear entry, count and `overflow`.
  - `#` with count==0: no `num_valid`, no change.
  - A–D: strobe only; entry unchanged. Downstream uses them as operator keys.
- Simultaneous events:
  - `pressed_valid` toggling outside IDLE/WAIT_LOW is ignored.
  - Captured col/row values are stable from CAPTURE onward, even if the inputs change.

Decomposition:
- `keypad_pkg`:
  - `key_code_t` (4 bits);
  - constants `KEY_STAR`=0xE, `KEY_HASH`=0xF, `KEY_A`..`KEY_D`;
  - FSM enum `lector_state_t`;
  - the 4×4 key map as a localparam array.
- Sub-module `keypad_decode`: a registered one-hot→code decoder with a `valid_onehot` flag, instantiated for the CAPTURE stage.

Test Plan:
1. Reset mid-WAIT_LOW with `pressed_valid`=1 → next cycle: state IDLE, all outputs 0. The key is re-accepted only on a new `pressed_valid` seen in IDLE.
2. Keys 4, 2, 7, #. Each key: `pressed_valid` held high until one cycle after `ack_read` → exactly 4 `ack_read` pulses. `entry_bcd` goes 0x004, 0x042, 0x427. On #: `num_out`=0x427, `num_valid` one pulse; `entry_bcd`=0, `digit_count`=0.
3. Keys 1, 2, 3, 5 → `entry_bcd`=0x123, `overflow`=1. Then * → `entry_bcd`=0, `overflow`=0, no `num_valid`.
4. col=4'b0110, row=4'b0001 → `key_error` pulse, `ack_read` pulse, no `key_strobe`, entry unchanged.
5. Scanner ignores the ack; `pressed_valid` stays high 40 cycles → initial `ack_read` plus re-pulses every 16 cycles in WAIT_LOW (3 total). Single `key_strobe`.
6. # with an empty buffer → `key_strobe`, `key_code`=0xF, no `num_valid`, `num_out` unchanged. Then key D → `key_code`=0xD, `entry_bcd` unchanged.
